// File: rtl/lstx_fifo.sv
// Low-speed serial transmitter: toggle-push write FIFO feeding a framing FSM with
// runtime-selectable length, parity, stop bits and bit order; bit timing from clk or fclk.
`timescale 1ns/1ps
module lstx_fifo #(
  parameter int unsigned BMSB = 3,
  parameter int unsigned DMSB = 9,
  parameter int unsigned CMSB = 12,
  parameter int unsigned AMSB = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            setn,
  input  logic            push,
  input  logic            clear,
  input  logic [DMSB:0]   wdata,
  input  logic [CMSB:0]   div,
  input  logic            fclk,
  input  logic            sel_fclk,
  input  logic [BMSB:0]   nbits,
  input  logic            par_en,
  input  logic            par_odd,
  input  logic            stop2,
  input  logic            msb_first,
  output logic            tx,
  output logic            empty,
  output logic            full,
  output logic [AMSB+1:0] level,
  output logic            ovf,
  output logic            done,
  output logic [2:0]      xst
);

  localparam int unsigned     DEPTH   = 2 ** (AMSB + 1);
  localparam logic [AMSB+1:0] LvlFull = (AMSB + 2)'(DEPTH);
  localparam logic [BMSB:0]   NbMax   = (BMSB + 1)'(DMSB);
  localparam logic [CMSB:0]   DivOne  = (CMSB + 1)'(1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // FIFO
  logic [DMSB:0]   r_mem [DEPTH];
  logic [AMSB:0]   r_wptr, r_rptr;
  logic [AMSB+1:0] r_level;
  logic            r_push_d, r_ovf;
  logic            w_push, w_wr, w_load;

  assign empty  = (r_level == '0);
  assign full   = (r_level == LvlFull);
  assign level  = r_level;
  assign ovf    = r_ovf;
  assign w_push = push ^ r_push_d;
  // A pop in the same cycle frees the head slot, so a push into a full FIFO still fits.
  assign w_wr   = w_push && !clear && (!full || w_load);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push_d <= 1'b0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_push_d <= push;
      if (clear) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
        r_ovf   <= 1'b0;
      end else begin
        if (w_wr)   r_wptr <= r_wptr + 1'b1;
        if (w_load) r_rptr <= r_rptr + 1'b1;
        if (w_wr && !w_load)      r_level <= r_level + 1'b1;
        else if (!w_wr && w_load) r_level <= r_level - 1'b1;
        if (w_push && full && !w_load) r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= wdata;
  end

  // Tick generation: fclk rising edges after a two-flop synchroniser
  logic r_fs1, r_fs2, r_fs3;
  logic w_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fs1 <= 1'b0;
      r_fs2 <= 1'b0;
      r_fs3 <= 1'b0;
    end else begin
      r_fs1 <= fclk;
      r_fs2 <= r_fs1;
      r_fs3 <= r_fs2;
    end
  end

  assign w_tick = sel_fclk ? (r_fs2 & ~r_fs3) : 1'b1;

  // Frame FSM
  logic [2:0]    r_xst, w_xst_d;
  logic [CMSB:0] r_cnt, w_cnt_d, r_div, w_div_d;
  logic [BMSB:0] r_nbits, w_nbits_d, r_bidx, w_bidx_d, w_nb;
  logic [DMSB:0] r_sh, w_sh_d;
  logic          r_par, w_par_d, r_scnt, w_scnt_d, r_done, w_done_d, r_tx, w_tx_d;
  logic          r_par_en, w_par_en_d, r_stop2, w_stop2_d, r_msb, w_msb_d;
  logic          w_bit_end, w_bit;

  assign w_nb      = (nbits > NbMax) ? NbMax : nbits;
  assign w_bit_end = w_tick && (r_cnt == r_div - 1'b1);
  // MSB-first words are left-justified so the next bit always sits at DMSB.
  assign w_bit     = r_msb ? r_sh[DMSB] : r_sh[0];

  always_comb begin
    w_xst_d    = r_xst;
    w_cnt_d    = r_cnt;
    w_div_d    = r_div;
    w_nbits_d  = r_nbits;
    w_bidx_d   = r_bidx;
    w_sh_d     = r_sh;
    w_par_d    = r_par;
    w_scnt_d   = r_scnt;
    w_par_en_d = r_par_en;
    w_stop2_d  = r_stop2;
    w_msb_d    = r_msb;
    w_done_d   = 1'b0;
    w_load     = 1'b0;
    if (!setn) begin
      w_xst_d = IDLE;
      w_cnt_d = '0;
    end else begin
      if (r_xst != IDLE && w_tick) w_cnt_d = w_bit_end ? '0 : r_cnt + 1'b1;
      case (r_xst)
        IDLE: w_load = !empty;
        START: begin
          if (w_bit_end) begin
            w_xst_d  = DATA;
            w_bidx_d = '0;
          end
        end
        DATA: begin
          if (w_bit_end) begin
            w_par_d = r_par ^ w_bit;
            w_sh_d  = r_msb ? (r_sh << 1) : (r_sh >> 1);
            if (r_bidx == r_nbits) begin
              w_xst_d  = r_par_en ? PARITY : STOP;
              w_scnt_d = 1'b0;
            end else begin
              w_bidx_d = r_bidx + 1'b1;
            end
          end
        end
        PARITY: begin
          if (w_bit_end) begin
            w_xst_d  = STOP;
            w_scnt_d = 1'b0;
          end
        end
        STOP: begin
          if (w_bit_end) begin
            if (r_stop2 && !r_scnt) begin
              w_scnt_d = 1'b1;
            end else begin
              w_done_d = 1'b1;
              w_xst_d  = IDLE;
              w_load   = !empty;
            end
          end
        end
        default: w_xst_d = IDLE;
      endcase
      if (w_load) begin
        w_xst_d    = START;
        w_cnt_d    = '0;
        w_par_d    = par_odd;
        w_div_d    = (div == '0) ? DivOne : div;
        w_nbits_d  = w_nb;
        w_par_en_d = par_en;
        w_stop2_d  = stop2;
        w_msb_d    = msb_first;
        w_sh_d     = msb_first ? (r_mem[r_rptr] << (NbMax - w_nb)) : r_mem[r_rptr];
      end
    end
  end

  always_comb begin
    case (w_xst_d)
      START:   w_tx_d = 1'b0;
      DATA:    w_tx_d = w_msb_d ? w_sh_d[DMSB] : w_sh_d[0];
      PARITY:  w_tx_d = w_par_d;
      default: w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xst    <= IDLE;
      r_cnt    <= '0;
      r_div    <= '0;
      r_nbits  <= '0;
      r_bidx   <= '0;
      r_sh     <= '0;
      r_par    <= 1'b0;
      r_scnt   <= 1'b0;
      r_par_en <= 1'b0;
      r_stop2  <= 1'b0;
      r_msb    <= 1'b0;
      r_done   <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_xst    <= w_xst_d;
      r_cnt    <= w_cnt_d;
      r_div    <= w_div_d;
      r_nbits  <= w_nbits_d;
      r_bidx   <= w_bidx_d;
      r_sh     <= w_sh_d;
      r_par    <= w_par_d;
      r_scnt   <= w_scnt_d;
      r_par_en <= w_par_en_d;
      r_stop2  <= w_stop2_d;
      r_msb    <= w_msb_d;
      r_done   <= w_done_d;
      r_tx     <= w_tx_d;
    end
  end

  assign tx   = r_tx;
  assign done = r_done;
  assign xst  = r_xst;

endmodule
